// File: rtl/vga_pkg.sv
// Shared definitions for the XGA video blocks: pattern mode codes,
// XGA 1024x768@70 timing numbers and the width helper used by the tops.
package vga_pkg;

    // Pattern mode encoding
    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CHECK = 2'd1;
    localparam logic [1:0] MODE_BOX   = 2'd2;
    localparam logic [1:0] MODE_GRAD  = 2'd3;

    // XGA 1024x768 timing (75 MHz pixel clock)
    localparam int H_ACTIVE = 32'd1024;
    localparam int H_FP     = 32'd24;
    localparam int H_SYNC   = 32'd136;
    localparam int H_BP     = 32'd144;
    localparam int H_TOTAL  = 32'd1328;
    localparam int V_ACTIVE = 32'd768;
    localparam int V_FP     = 32'd3;
    localparam int V_SYNC   = 32'd6;
    localparam int V_BP     = 32'd29;
    localparam int V_TOTAL  = 32'd806;

    // Number of bits needed to count 0..value-1
    function automatic int clog2(input int value);
        int rem;
        int bits;
        bits = 32'sd0;
        rem  = value - 32'sd1;
        while (rem > 32'sd0) begin
            bits = bits + 32'sd1;
            rem  = rem >>> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel position in, pixel colour out, between vga_driver and a pattern source.
interface vga_pattern_gen_if
    import vga_pkg::*;
#(
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 768,
    parameter int COLOR_DEPTH = 8
);
    localparam int HW = clog2(WIDTH);
    localparam int VW = clog2(HEIGHT);

    logic [HW-1:0]          h_pos;
    logic [VW-1:0]          v_pos;
    logic [COLOR_DEPTH-1:0] vga_r;
    logic [COLOR_DEPTH-1:0] vga_g;
    logic [COLOR_DEPTH-1:0] vga_b;

    // Timing side: produces position, consumes colour
    modport master (output h_pos, v_pos, input vga_r, vga_g, vga_b);
    // Pattern side: consumes position, produces colour
    modport slave  (input h_pos, v_pos, output vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_bounce_ctr.sv
// One axis of the bouncing box: position walks 0..LIMIT and reverses at
// either end, one step per frame tick.
module vga_bounce_ctr #(
    parameter int W     = 10,
    parameter int LIMIT = 960
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    output logic [W-1:0] pos
);
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] pos_r;
    logic [W-1:0] pos_nxt_s;
    logic         dir_r;       // 1 = moving up (+1), 0 = moving down (-1)
    logic         dir_nxt_s;

    // Next position/direction: reflect at the ends, otherwise step
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        if (tick) begin
            if (dir_r && (pos_r == LIMIT_V)) begin
                dir_nxt_s = 1'b0;
                pos_nxt_s = pos_r - ONE;
            end else if (!dir_r && (pos_r == {W{1'b0}})) begin
                dir_nxt_s = 1'b1;
                pos_nxt_s = ONE;
            end else if (dir_r) begin
                pos_nxt_s = pos_r + ONE;
            end else begin
                pos_nxt_s = pos_r - ONE;
            end
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // Position/direction state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= {W{1'b0}};
            dir_r <= 1'b1;
        end else begin
            pos_r <= pos_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

    assign pos = pos_r;
endmodule

// File: rtl/vga_pattern_gen.sv
// Animated test-pattern source for the XGA top. Four patterns selected by a
// push button, animation advanced once per frame, colour valid two clocks
// after the position is presented.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 768,
    parameter int COLOR_DEPTH = 8,
    parameter int BOX_SIZE    = 64,
    parameter int CHECK_LOG2  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_n,
    output logic [1:0]              mode,
    vga_pattern_gen_if.slave        pix
);
    localparam int HW = clog2(WIDTH);
    localparam int VW = clog2(HEIGHT);

    localparam logic [COLOR_DEPTH-1:0] FULL      = {COLOR_DEPTH{1'b1}};
    localparam logic [COLOR_DEPTH-1:0] ZERO      = {COLOR_DEPTH{1'b0}};
    localparam logic [COLOR_DEPTH-1:0] DARK_BLUE = COLOR_DEPTH'(8'h40);

    // Button synchroniser and edge detect
    logic sync1_r, sync2_r, step_prev_r;
    logic press_s;

    // Frame-level state
    logic [VW-1:0] v_pos_d_r;
    logic          frame_tick_s;
    logic [1:0]    pending_mode_r;
    logic [1:0]    mode_r;
    logic [7:0]    frame_cnt_r;
    logic [HW-1:0] box_x_s;
    logic [VW-1:0] box_y_s;

    // Pipeline stage 1 snapshot
    logic [HW-1:0] h1_r;
    logic [VW-1:0] v1_r;
    logic [1:0]    mode1_r;
    logic [HW-1:0] box_x1_r;
    logic [VW-1:0] box_y1_r;
    logic [7:0]    fc1_r;

    // Stage 2 colour
    logic [COLOR_DEPTH-1:0] r_s, g_s, b_s;
    logic [HW-1:0]          sum_s;
    logic                   in_range_s;
    logic                   in_box_s;
    logic [2:0]             bar_idx_s;

    // Two-flop synchroniser plus one registered copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            step_prev_r <= 1'b1;
        end else begin
            sync1_r     <= step_n;
            sync2_r     <= sync1_r;
            step_prev_r <= sync2_r;
        end
    end

    assign press_s      = step_prev_r & ~sync2_r;
    assign frame_tick_s = (v_pos_d_r == VW'(HEIGHT - 1)) && (pix.v_pos == {VW{1'b0}});

    // Mode selection and frame counter; mode only changes on the frame tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pos_d_r      <= {VW{1'b0}};
            pending_mode_r <= MODE_BARS;
            mode_r         <= MODE_BARS;
            frame_cnt_r    <= 8'd0;
        end else begin
            v_pos_d_r <= pix.v_pos;
            if (press_s) begin
                pending_mode_r <= pending_mode_r + 2'd1;
            end
            if (frame_tick_s) begin
                mode_r      <= pending_mode_r;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    vga_bounce_ctr #(.W(HW), .LIMIT(WIDTH - BOX_SIZE)) u_bounce_x (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (frame_tick_s),
        .pos   (box_x_s)
    );

    vga_bounce_ctr #(.W(VW), .LIMIT(HEIGHT - BOX_SIZE)) u_bounce_y (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (frame_tick_s),
        .pos   (box_y_s)
    );

    // Stage 1: capture position together with the animation snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_r     <= {HW{1'b0}};
            v1_r     <= {VW{1'b0}};
            mode1_r  <= MODE_BARS;
            box_x1_r <= {HW{1'b0}};
            box_y1_r <= {VW{1'b0}};
            fc1_r    <= 8'd0;
        end else begin
            h1_r     <= pix.h_pos;
            v1_r     <= pix.v_pos;
            mode1_r  <= mode_r;
            box_x1_r <= box_x_s;
            box_y1_r <= box_y_s;
            fc1_r    <= frame_cnt_r;
        end
    end

    assign in_range_s = ({1'b0, h1_r} < (HW+1)'(WIDTH)) && ({1'b0, v1_r} < (VW+1)'(HEIGHT));
    assign sum_s      = h1_r + HW'(fc1_r);
    assign bar_idx_s  = h1_r[HW-1 -: 3];
    assign in_box_s   = (h1_r >= box_x1_r)
                     && ({1'b0, h1_r} < ({1'b0, box_x1_r} + (HW+1)'(BOX_SIZE)))
                     && (v1_r >= box_y1_r)
                     && ({1'b0, v1_r} < ({1'b0, box_y1_r} + (VW+1)'(BOX_SIZE)));

    // Stage 2 colour: pattern select, blanked outside the active area
    always_comb begin
        r_s = ZERO;
        g_s = ZERO;
        b_s = ZERO;
        if (in_range_s) begin
            case (mode1_r)
                MODE_BARS: begin
                    r_s = bar_idx_s[0] ? FULL : ZERO;
                    g_s = bar_idx_s[1] ? FULL : ZERO;
                    b_s = bar_idx_s[2] ? FULL : ZERO;
                end
                MODE_CHECK: begin
                    r_s = (sum_s[CHECK_LOG2] ^ v1_r[CHECK_LOG2]) ? FULL : ZERO;
                    g_s = r_s;
                    b_s = r_s;
                end
                MODE_BOX: begin
                    r_s = in_box_s ? FULL : ZERO;
                    b_s = in_box_s ? ZERO : DARK_BLUE;
                end
                MODE_GRAD: begin
                    r_s = h1_r[HW-1 -: COLOR_DEPTH];
                    g_s = v1_r[VW-1 -: COLOR_DEPTH];
                    b_s = fc1_r[7 -: COLOR_DEPTH];
                end
                default: begin
                    r_s = ZERO;
                    g_s = ZERO;
                    b_s = ZERO;
                end
            endcase
        end else begin
            r_s = ZERO;
            g_s = ZERO;
            b_s = ZERO;
        end
    end

    // Registered colour outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix.vga_r <= ZERO;
            pix.vga_g <= ZERO;
            pix.vga_b <= ZERO;
        end else begin
            pix.vga_r <= r_s;
            pix.vga_g <= g_s;
            pix.vga_b <= b_s;
        end
    end

    assign mode = mode_r;
endmodule
